// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg -- shared I2C constants, FSM encoding and helpers.  Rev 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam logic [6:0] c_DEV_ADDR = 7'h50;
  localparam logic       c_ACK      = 1'b0;
  localparam logic       c_NACK     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_ACK_DEV   = 4'd2,
    ST_REG       = 4'd3,
    ST_ACK_REG   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_ACK_WDATA = 4'd6,
    ST_RDATA     = 4'd7,
    ST_MACK      = 4'd8
  } i2c_state_t;

  // Register pointer advance; mask is (depth - 1) for a power-of-two depth.
  function automatic logic [7:0] ptr_inc(input logic [7:0] p, input logic [7:0] mask);
    return (p + 8'd1) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// i2c_bus_sync -- SCL/SDA synchronizers with edge and START/STOP detect. Rev 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0] metastability flop, [1] synchronized level, [2] history for edges
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  logic w_scl_high;
  assign w_scl_high = r_scl[1] & r_scl[2];

  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = w_scl_high & r_sda[2] & ~r_sda[1];
  assign o_stop     = w_scl_high & ~r_sda[2] & r_sda[1];

endmodule

`default_nettype wire

// File: rtl/i2c_slave_regs.sv
// ============================================================================
// i2c_slave_regs -- I2C target exposing a byte-wide register file.  Rev 1.0
// ============================================================================
`default_nettype none

module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = c_DEV_ADDR,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int         PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] c_PTR_MASK = 8'(NUM_REGS - 1);
  localparam logic [8:0] c_DEPTH    = 9'(NUM_REGS);

  logic w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (SCL_in),
    .i_sda      (SDA_in),
    .o_sda      (w_sda_s),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_t r_state, w_state;
  logic [2:0] r_cnt, w_cnt;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_ptr, w_ptr;
  logic [7:0] r_tx, w_tx;
  logic       r_ph, w_ph;       // set once the first SCL fall of an ACK phase has passed
  logic       r_rw, w_rw;
  logic       r_mack, w_mack;
  logic       r_sda_out, w_sda_out;
  logic       r_busy, w_busy;
  logic       r_wr_stb, w_wr_stb;
  logic [7:0] r_wr_addr, w_wr_addr;
  logic [7:0] r_wr_data, w_wr_data;
  logic       w_we;

  logic [7:0] r_regs [NUM_REGS];
  logic [7:0] w_ptr_nxt;
  logic [7:0] w_rd_cur;
  logic [7:0] w_rd_nxt;

  assign w_ptr_nxt = ptr_inc(r_ptr, c_PTR_MASK);
  assign w_rd_cur  = r_regs[r_ptr[PTR_W-1:0]];
  assign w_rd_nxt  = r_regs[w_ptr_nxt[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd7;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_tx      <= '0;
      r_ph      <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= c_NACK;
      r_sda_out <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_ptr     <= w_ptr;
      r_tx      <= w_tx;
      r_ph      <= w_ph;
      r_rw      <= w_rw;
      r_mack    <= w_mack;
      r_sda_out <= w_sda_out;
      r_busy    <= w_busy;
      r_wr_stb  <= w_wr_stb;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[r_ptr[PTR_W-1:0]] <= r_shift;
    end
  end

  // SDA_out updates are only scheduled on an SCL-fall strobe, so the pin
  // moves on the following clk; START/STOP release it immediately.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_ptr     = r_ptr;
    w_tx      = r_tx;
    w_ph      = r_ph;
    w_rw      = r_rw;
    w_mack    = r_mack;
    w_sda_out = r_sda_out;
    w_busy    = r_busy;
    w_wr_stb  = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_we      = 1'b0;

    if (w_start) begin
      w_state   = ST_DEV;
      w_cnt     = 3'd7;
      w_ph      = 1'b0;
      w_sda_out = 1'b1;
      w_busy    = 1'b1;
    end else if (w_stop) begin
      w_state   = ST_IDLE;
      w_cnt     = 3'd7;
      w_ph      = 1'b0;
      w_sda_out = 1'b1;
      w_busy    = 1'b0;
    end else begin
      case (r_state)
        ST_DEV: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], w_sda_s};
            if (r_cnt == 3'd0) begin
              if (w_shift[7:1] == DEV_ADDR) begin
                w_state = ST_ACK_DEV;
                w_rw    = w_sda_s;
                w_ph    = 1'b0;
              end else begin
                w_state   = ST_IDLE;
                w_cnt     = 3'd7;
                w_sda_out = 1'b1;
              end
            end else begin
              w_cnt = r_cnt - 3'd1;
            end
          end
        end

        ST_ACK_DEV: begin
          if (w_scl_fall) begin
            if (!r_ph) begin
              w_sda_out = c_ACK;
              w_ph      = 1'b1;
            end else begin
              w_cnt = 3'd7;
              w_ph  = 1'b0;
              if (r_rw) begin
                w_state   = ST_RDATA;
                w_sda_out = w_rd_cur[7];
                w_tx      = {w_rd_cur[6:0], 1'b0};
              end else begin
                w_state   = ST_REG;
                w_sda_out = 1'b1;
              end
            end
          end
        end

        ST_REG: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], w_sda_s};
            if (r_cnt == 3'd0) begin
              w_ptr   = w_shift;
              w_state = ST_ACK_REG;
              w_ph    = 1'b0;
            end else begin
              w_cnt = r_cnt - 3'd1;
            end
          end
        end

        ST_ACK_REG: begin
          if (w_scl_fall) begin
            if (!r_ph) begin
              if ({1'b0, r_ptr} < c_DEPTH) begin
                w_sda_out = c_ACK;
                w_ph      = 1'b1;
              end else begin
                w_sda_out = c_NACK;
                w_state   = ST_IDLE;
                w_cnt     = 3'd7;
              end
            end else begin
              w_state   = ST_WDATA;
              w_sda_out = 1'b1;
              w_cnt     = 3'd7;
              w_ph      = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], w_sda_s};
            if (r_cnt == 3'd0) begin
              w_state = ST_ACK_WDATA;
              w_ph    = 1'b0;
            end else begin
              w_cnt = r_cnt - 3'd1;
            end
          end
        end

        ST_ACK_WDATA: begin
          if (w_scl_fall) begin
            if (!r_ph) begin
              w_sda_out = c_ACK;
              w_ph      = 1'b1;
            end else begin
              w_we      = 1'b1;
              w_wr_stb  = 1'b1;
              w_wr_addr = r_ptr;
              w_wr_data = r_shift;
              w_ptr     = w_ptr_nxt;
              w_state   = ST_WDATA;
              w_sda_out = 1'b1;
              w_cnt     = 3'd7;
              w_ph      = 1'b0;
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_fall) begin
            w_sda_out = r_tx[7];
            w_tx      = {r_tx[6:0], 1'b0};
          end else if (w_scl_rise) begin
            if (r_cnt == 3'd0) begin
              w_state = ST_MACK;
              w_ph    = 1'b0;
            end else begin
              w_cnt = r_cnt - 3'd1;
            end
          end
        end

        ST_MACK: begin
          if (w_scl_fall) begin
            if (!r_ph) begin
              w_sda_out = 1'b1;
              w_ph      = 1'b1;
            end else begin
              w_cnt = 3'd7;
              w_ph  = 1'b0;
              if (r_mack == c_ACK) begin
                w_ptr     = w_ptr_nxt;
                w_state   = ST_RDATA;
                w_sda_out = w_rd_nxt[7];
                w_tx      = {w_rd_nxt[6:0], 1'b0};
              end else begin
                w_state = ST_IDLE;
              end
            end
          end else if (w_scl_rise && r_ph) begin
            w_mack = w_sda_s;
          end
        end

        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign SDA_out = r_sda_out;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
// ============================================================================
// tb_i2c_slave_regs -- bit-banged I2C master driving the register target. Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave_regs;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       SDA_out;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int low_cnt = 0;
  logic low_en = 1'b0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  model[16];

  assign sda_line = sda_m & SDA_out;

  i2c_slave_regs #(.DEV_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .SCL_in  (scl),
    .SDA_in  (sda_line),
    .SDA_out (SDA_out),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      stb_cnt++;
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_wr_stb", {wr_addr, wr_data}, 16'hxxxx);
      end else begin
        chk("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
    if (low_en && SDA_out === 1'b0) low_cnt++;
  end

  task automatic q();
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b; q();
    scl = 1'b1; q();
    r = sda_line; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    sda_m = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic send_chk(input logic [7:0] b, input logic exp_ack, input string tag);
    logic d;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], d);
    xfer_bit(1'b1, d);
    chk(tag, {31'd0, d}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic mack, input string tag);
    logic [7:0] v;
    logic d;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, d);
      v[i] = d;
    end
    xfer_bit(mack, d);
    if (exp_rd_q.size() == 0) chk({tag, "_noexp"}, {24'd0, v}, 32'hxxxxxxxx);
    else chk(tag, {24'd0, v}, {24'd0, exp_rd_q.pop_front()});
  endtask

  task automatic wr_reg(input logic [7:0] r, input logic [7:0] d);
    i2c_start();
    send_chk(8'hA0, c_ACK, "wr_dev_ack");
    send_chk(r, c_ACK, "wr_reg_ack");
    exp_wr_q.push_back({r, d});
    model[r[3:0]] = d;
    send_chk(d, c_ACK, "wr_data_ack");
    i2c_stop();
  endtask

  task automatic rd_regs(input logic [7:0] r, input int n);
    i2c_start();
    send_chk(8'hA0, c_ACK, "rd_dev_ack");
    send_chk(r, c_ACK, "rd_reg_ack");
    i2c_start();
    send_chk(8'hA1, c_ACK, "rd_devr_ack");
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(model[4'(r + 8'(k))]);
      read_byte((k == n - 1) ? c_NACK : c_ACK, "rd_byte");
    end
    q();
    chk("rd_end_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rd_end_busy", {31'd0, busy}, 32'd1);
    i2c_stop();
    q();
    chk("rd_stop_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s0;
    logic d;
    bit seen;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    repeat (4) @(negedge clk);
    chk("rst_sda_out", {31'd0, SDA_out}, 32'd1);
    chk("rst_wr_stb",  {31'd0, wr_stb},  32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single write 0x03 <= 0xA5
    s0 = stb_cnt;
    i2c_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_chk(8'hA0, c_ACK, "w1_dev_ack");
    send_chk(8'h03, c_ACK, "w1_reg_ack");
    exp_wr_q.push_back(16'h03A5);
    model[3] = 8'hA5;
    send_chk(8'hA5, c_ACK, "w1_data_ack");
    i2c_stop();
    q();
    chk("w1_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("w1_stb_count", 32'(stb_cnt - s0), 32'd1);

    // two bytes from 0x0F: pointer wraps to 0
    s0 = stb_cnt;
    i2c_start();
    send_chk(8'hA0, c_ACK, "w2_dev_ack");
    send_chk(8'h0F, c_ACK, "w2_reg_ack");
    exp_wr_q.push_back(16'h0F11);
    model[15] = 8'h11;
    send_chk(8'h11, c_ACK, "w2_d0_ack");
    exp_wr_q.push_back(16'h0022);
    model[0] = 8'h22;
    send_chk(8'h22, c_ACK, "w2_d1_ack");
    i2c_stop();
    q();
    chk("w2_stb_count", 32'(stb_cnt - s0), 32'd2);
    rd_regs(8'h0F, 2);

    // wrong address: NACK and bus left alone
    s0 = stb_cnt;
    low_cnt = 0;
    low_en = 1'b1;
    i2c_start();
    send_chk(8'hA2, c_NACK, "bad_dev_nack");
    send_chk(8'h03, c_NACK, "bad_reg_ignored");
    send_chk(8'h77, c_NACK, "bad_data_ignored");
    i2c_stop();
    q();
    low_en = 1'b0;
    chk("bad_sda_low_cycles", 32'(low_cnt), 32'd0);
    chk("bad_stb_count", 32'(stb_cnt - s0), 32'd0);

    // repeated-start read of 0x03 then 0x04
    wr_reg(8'h04, 8'h3C);
    rd_regs(8'h03, 2);

    // out-of-range register pointer
    i2c_start();
    send_chk(8'hA0, c_ACK, "oor_dev_ack");
    send_chk(8'h20, c_NACK, "oor_reg_nack");
    chk("oor_state", 32'(dut.r_state), 32'(ST_IDLE));
    i2c_stop();

    // STOP after 4 data bits discards the byte
    wr_reg(8'h05, 8'h66);
    s0 = stb_cnt;
    i2c_start();
    send_chk(8'hA0, c_ACK, "part_dev_ack");
    send_chk(8'h05, c_ACK, "part_reg_ack");
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, d);
    i2c_stop();
    q();
    chk("part_stb_count", 32'(stb_cnt - s0), 32'd0);
    rd_regs(8'h05, 1);

    // reset while the target is pulling SDA low
    i2c_start();
    for (int i = 7; i >= 0; i--) xfer_bit(1'(8'hA0 >> i), d);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (SDA_out === 1'b0) seen = 1'b1;
    end
    chk("ack_low_before_rst", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("sda_released_after_rst", {31'd0, SDA_out}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    i2c_stop();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    // after reset: pointer at 0 and register file cleared
    i2c_start();
    send_chk(8'hA1, c_ACK, "post_rst_dev_ack");
    exp_rd_q.push_back(8'h00);
    read_byte(c_NACK, "post_rst_reg0");
    i2c_stop();
    rd_regs(8'h03, 1);

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50: the 7-bit I2C address this target answers to.
REQ-002 The block SHALL have parameter NUM_REGS, default 16: the register-file depth, a power of two no larger than 256.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port SCL_in, input, 1 bit: the bus clock driven by the master; it is asynchronous to clk.
REQ-006 The block SHALL have port SDA_in, input, 1 bit: the resolved bus data line; it is asynchronous to clk.
REQ-007 The block SHALL have port SDA_out, output, 1 bit: open-drain model, where 0 pulls the line low and 1 releases it.
REQ-008 The block SHALL have port wr_stb, output, 1 bit: a one-cycle pulse that fires when a data byte is committed to the register file.
REQ-009 The block SHALL have port wr_addr, output, 8 bits: the register index of the last committed write.
REQ-010 The block SHALL have port wr_data, output, 8 bits: the data byte of the last committed write.
REQ-011 The block SHALL have port busy, output, 1 bit: high from a detected START until a detected STOP.

Function
REQ-012 The block SHALL pass SCL_in and SDA_in through 2-flop synchronizers, then one history flop each for edge detection (latency 3 clk).
REQ-013 The block SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as a synchronized SDA rise while SCL is high; both are valid in any state.
REQ-014 The block SHALL sample SDA only on a synchronized SCL rise.
REQ-015 The block SHALL change SDA_out only on the cycle after a synchronized SCL fall.
REQ-016 The FSM SHALL have the states IDLE, DEV, ACK_DEV, REG, ACK_REG, WDATA, ACK_WDATA, RDATA, MACK.
REQ-017 From IDLE, a START SHALL go to DEV with bit counter=7.
REQ-018 In DEV, the block SHALL shift in 8 bits MSB-first (address[6:0] then RW).
REQ-019 At the end of DEV, an address match SHALL go to ACK_DEV; a mismatch SHALL go to IDLE, release SDA and ignore the bus until the next START.
REQ-020 In ACK_DEV, the block SHALL drive 0 for one SCL period; it SHALL then go to RDATA if RW=1, else to REG.
REQ-021 In REG, the block SHALL shift in 8 bits into the pointer.
REQ-022 In ACK_REG, the block SHALL ACK if pointer<NUM_REGS, then go to WDATA; otherwise it SHALL NACK (release SDA) and go to IDLE.
REQ-023 In WDATA, the block SHALL shift in 8 bits.
REQ-024 At the end of ACK_WDATA, the block SHALL write regs[ptr], pulse wr_stb for one clk, update wr_addr/wr_data, and increment ptr modulo NUM_REGS.
REQ-025 After ACK_WDATA, the block SHALL return to WDATA.
REQ-026 In RDATA, the block SHALL drive regs[ptr] MSB-first, loaded at the first SCL fall after the ACK.
REQ-027 In MACK, the block SHALL release SDA and sample the master bit. On 0 (ACK) it SHALL increment ptr (wrapping) and go to RDATA. On 1 (NACK) it SHALL go to IDLE and wait for STOP.
REQ-028 A repeated START mid-transfer SHALL abort the current byte without a write and go to DEV; ptr SHALL be kept so that a read after a register-address write returns that register.
REQ-029 A STOP in any state SHALL release SDA, return to IDLE and clear busy; a partial byte SHALL be discarded.
REQ-030 If a START and a STOP are detected in the same clk, START SHALL take priority.
REQ-031 The bit counter SHALL wrap from 0 to 7 at the end of each ACK phase.

Reset
REQ-032 On rst, the block SHALL set state=IDLE, SDA_out=1, wr_stb=0, wr_addr=0, wr_data=0, busy=0, ptr=0 and bit counter=7, and fill the synchronizers with 1.
REQ-033 Register-file contents SHALL reset to 0.
REQ-034 A reset mid-transfer SHALL release SDA on the next clk, and the interrupted byte SHALL never be written.

Structure
REQ-035 FSM state encodings, the default DEV_ADDR and the ACK/NACK constants SHALL live in the shared package i2c_pkg, also imported by the master.
REQ-036 Synchronizer plus START/STOP/edge detection SHALL be one sub-module, i2c_bus_sync, so the master can reuse it.

Verification
REQ-037 The bench SHALL write addr 0x50, reg 0x03, data 0xA5, then STOP; required response: 3 ACKs, wr_stb pulses once with wr_addr=0x03 and wr_data=0xA5, and regs[3]=0xA5.
REQ-038 The bench SHALL write reg 0x0F with 0x11 then 0x22; required response: regs[15]=0x11, regs[0]=0x22 (pointer wrap), and 2 wr_stb pulses.
REQ-039 The bench SHALL send address 0x51; required response: NACK at the 9th SCL, SDA_out stays 1 for the rest of the transfer, and no wr_stb.
REQ-040 The bench SHALL write reg 0x03, repeated START, read 0x50 with RW=1, master ACK, then master NACK; required response: bytes 0xA5 then regs[4] are returned, followed by IDLE.
REQ-041 The bench SHALL write register address 0x20; required response: NACK at ACK_REG and state=IDLE.
REQ-042 The bench SHALL STOP after 4 bits of a data byte, then assert rst while SDA_out=0; required response: no write occurs, and SDA_out=1 one clk after rst.
